mdr_divider: RTL and testbench
==============================

# mdr_divider

Sequential restoring divider for the multiply/divide/root (MDR) datapath. Accepts a dividend/divisor pair on a start strobe, iterates one quotient bit per clock, and presents quotient, remainder and an error flag with a one-cycle done pulse. It sits directly upstream of the result-capture stage: `o_done` drives that stage's `i_done` and `o_quotient` drives its `i_data`.

## Interface
- `DW`, default 16 (package constant `MDR_DW`): operand, quotient and remainder width in bits; must be ≥ 2.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `i_start` in 1: start request, sampled only in IDLE.
- `i_dividend` in DW: dividend, captured on the accepted start edge.
- `i_divisor` in DW: divisor, captured on the accepted start edge.
- `o_busy` in/out direction out, 1: high from the cycle after acceptance until `o_done` is asserted.
- `o_done` out 1: single-cycle completion pulse.
- `o_quotient` out DW: quotient, held until the next completion.
- `o_remainder` out DW: remainder, held until the next completion.
- `o_err` out 1: divide-by-zero or signed overflow; valid with `o_done` and held with the results.

## Operation
- FSM states: IDLE → CALC → FIX → IDLE. No other states.
- IDLE with `i_start`=1:
  - Capture operands; in signed mode, capture their magnitudes and record the signs.
  - Clear the partial remainder (DW+1 bits) and the iteration counter; go to CALC.
- CALC, one restoring step per cycle:
  - Shift the partial remainder left and bring in the next dividend MSB.
  - Trial-subtract the divisor. If the result is non-negative, keep it and set quotient bit = 1; otherwise restore and set quotient bit = 0.
  - After exactly DW steps (counter DW-1), go to FIX.
- FIX:
  - Apply sign correction when signed mode is compiled in.
  - Apply error overrides, register the results, pulse `o_done`, return to IDLE.
- Divide by zero (captured divisor = 0):
  - Latency is unchanged: the block still runs DW CALC cycles.
  - Results: `o_quotient`='1 (all ones), `o_remainder`=dividend as received, `o_err`=1.
- `i_start` outside IDLE is ignored. Operand changes after capture have no effect.
- Reset values: `o_busy`=0, `o_done`=0, `o_quotient`=0, `o_remainder`=0, `o_err`=0; FSM in IDLE.
- Reset mid-operation aborts the operation immediately. No `o_done` is produced and outputs return to their reset values.

## Timing
- Start sampled high at edge k:
  - `o_busy`=1 from edge k through edge k+DW+1.
  - Results and `o_done`=1 registered at edge k+DW+1; `o_done` drops at edge k+DW+2.
  - Latency is DW+1 cycles, independent of operand values.
- Back-to-back operation: the earliest next accepted start is edge k+DW+2, so throughput is one operation per DW+2 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `MDR_SIGNED_EN` defined:
  - Operands are two's complement. Quotient sign = sign(dividend) XOR sign(divisor). Remainder takes the dividend's sign, with |remainder| < |divisor|.
  - Most-negative / -1 yields `o_quotient`=most-negative, `o_remainder`=0, `o_err`=1.
  - Divide by zero behaves as in Operation; the remainder is the dividend as received, signed.
- `MDR_SIGNED_EN` not defined:
  - Operands are unsigned. No sign logic is generated; FIX only applies the error overrides.
  - Latency and ports are identical in both builds.

## Structure
- `pkg_system_mdr` holds:
  - `MDR_DW`.
  - `data_in_t` (logic [MDR_DW-1:0]), used for operand and result ports.
  - `mdr_div_state_t` enum {IDLE, CALC, FIX}.
- One sub-module, `mdr_div_step`:
  - Purely combinational single restoring iteration.
  - Inputs: partial remainder, incoming dividend bit, divisor.
  - Outputs: next partial remainder, quotient bit.
  - Instantiated once and reused each CALC cycle.

## Test plan
- DW=16, unsigned, 100 / 7 → q=14, r=2, `o_err`=0; `o_done` high exactly at edge k+17 for one cycle; `o_busy` high for cycles k+1..k+17.
- 1234 / 0 → q=0xFFFF, r=1234, `o_err`=1, same 17-cycle latency. Next op 10 / 3 → q=3, r=1, `o_err` cleared.
- `i_start` pulsed at k+5 during 500 / 9 with different operands → ignored. Result q=55, r=5; next start accepted at k+18.
- `rst` low at k+8 during 65535 / 1 → outputs 0, no `o_done`. After release, 65535 / 1 → q=65535, r=0.
- `MDR_SIGNED_EN`:
  - -100 / 7 → q=0xFFF2 (-14), r=0xFFFE (-2).
  - 100 / -7 → q=-14, r=2.
  - 0x8000 / 0xFFFF → q=0x8000, r=0, `o_err`=1.
- Outputs held: after completion, 40 idle cycles with random operands and `i_start`=0 → `o_quotient`, `o_remainder` and `o_err` unchanged; `o_done` stays 0.

Source files
------------

// File: rtl/mdr_divider_pkg.sv
// Shared types and constants for the MDR divider slice.
// No logic; types only.
// Consumers import with pkg_system_mdr::*.
package pkg_system_mdr;

  localparam int MDR_DW = 16;

  typedef logic [MDR_DW-1:0] data_in_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } mdr_div_state_t;

endpackage

// File: rtl/mdr_divider_if.sv
// Start/operand/result bundle between a requester and mdr_divider.
// No logic; wiring only.
// Requester holds no backpressure: start is accepted only while the divider is idle.
interface mdr_divider_if #(parameter int DW = pkg_system_mdr::MDR_DW);

  logic          i_start;
  logic [DW-1:0] i_dividend;
  logic [DW-1:0] i_divisor;
  logic          o_busy;
  logic          o_done;
  logic [DW-1:0] o_quotient;
  logic [DW-1:0] o_remainder;
  logic          o_err;

  modport master (
    output i_start, i_dividend, i_divisor,
    input  o_busy, o_done, o_quotient, o_remainder, o_err
  );

  modport slave (
    input  i_start, i_dividend, i_divisor,
    output o_busy, o_done, o_quotient, o_remainder, o_err
  );

endinterface

// File: rtl/mdr_divider_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract.
// Purely combinational, zero latency.
// No handshake; the caller sequences it once per clock.
module mdr_div_step #(
  parameter int DW = 16
) (
  input  logic [DW:0]   rem_in,
  input  logic          bit_in,
  input  logic [DW-1:0] divisor,
  output logic [DW:0]   rem_out,
  output logic          q_bit
);

  logic [DW:0] shifted;
  logic [DW:0] diff;

  // The partial remainder is always below the divisor, so the shifted value
  // fits in DW+1 bits and the MSB of the difference is a reliable sign bit.
  always_comb begin
    shifted = {rem_in[DW-1:0], bit_in};
    diff    = shifted - {1'b0, divisor};
    if (!diff[DW]) begin
      rem_out = diff;
      q_bit   = 1'b1;
    end else begin
      rem_out = shifted;
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/mdr_divider.sv
// Sequential restoring divider, one quotient bit per clock; MDR_SIGNED_EN selects two's complement operands.
// Latency DW+1 cycles from accepted start to o_done, independent of operands; one op per DW+2 cycles.
// No backpressure: i_start is sampled only in IDLE and ignored while busy; results held until next completion.
module mdr_divider
  import pkg_system_mdr::*;
#(
  parameter int DW = MDR_DW
) (
  input  logic           clk,
  input  logic           rst,
  mdr_divider_if.slave   bus
);

  localparam int CW = $clog2(DW);

  mdr_div_state_t state, state_nxt;

  logic [DW-1:0] dvd_q;      // dividend bits shift out the top, quotient bits shift in the bottom
  logic [DW-1:0] dvs_q;
  logic [DW-1:0] raw_dvd_q;  // dividend as received, reported on divide-by-zero
  logic [DW:0]   prem_q;
  logic [CW-1:0] cnt_q;
  logic          dz_q;

  logic          busy_q, done_q, err_q;
  logic [DW-1:0] quo_q, rem_q;

  logic [DW:0]   step_rem;
  logic          step_q;

  logic [DW-1:0] cap_dvd, cap_dvs;
  logic [DW-1:0] fix_quo, fix_rem;
  logic          fix_err;

`ifdef MDR_SIGNED_EN
  logic neg_q_q, neg_r_q, ovf_q;
`endif

  mdr_div_step #(.DW(DW)) u_step (
    .rem_in  (prem_q),
    .bit_in  (dvd_q[DW-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: fixed DW CALC cycles regardless of operands.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.i_start) state_nxt = CALC;
      CALC: if (cnt_q == CW'(DW - 1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand magnitudes presented to the unsigned iteration core.
  always_comb begin
    cap_dvd = bus.i_dividend;
    cap_dvs = bus.i_divisor;
`ifdef MDR_SIGNED_EN
    if (bus.i_dividend[DW-1]) cap_dvd = ~bus.i_dividend + 1'b1;
    if (bus.i_divisor[DW-1])  cap_dvs = ~bus.i_divisor + 1'b1;
`endif
  end

  // Final result: sign correction, then error overrides (divide-by-zero wins).
  always_comb begin
    fix_quo = dvd_q;
    fix_rem = prem_q[DW-1:0];
    fix_err = 1'b0;
`ifdef MDR_SIGNED_EN
    if (neg_q_q) fix_quo = ~dvd_q + 1'b1;
    if (neg_r_q) fix_rem = ~prem_q[DW-1:0] + 1'b1;
    if (ovf_q) begin
      fix_quo = {1'b1, {(DW-1){1'b0}}};
      fix_rem = '0;
      fix_err = 1'b1;
    end
`endif
    if (dz_q) begin
      fix_quo = '1;
      fix_rem = raw_dvd_q;
      fix_err = 1'b1;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd_q     <= '0;
      dvs_q     <= '0;
      raw_dvd_q <= '0;
      prem_q    <= '0;
      cnt_q     <= '0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
`ifdef MDR_SIGNED_EN
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            dvd_q     <= cap_dvd;
            dvs_q     <= cap_dvs;
            raw_dvd_q <= bus.i_dividend;
            prem_q    <= '0;
            cnt_q     <= '0;
            dz_q      <= (bus.i_divisor == '0);
            busy_q    <= 1'b1;
`ifdef MDR_SIGNED_EN
            neg_q_q   <= bus.i_dividend[DW-1] ^ bus.i_divisor[DW-1];
            neg_r_q   <= bus.i_dividend[DW-1];
            ovf_q     <= (bus.i_dividend == {1'b1, {(DW-1){1'b0}}}) && (bus.i_divisor == '1);
`endif
          end
        end
        CALC: begin
          prem_q <= step_rem;
          dvd_q  <= {dvd_q[DW-2:0], step_q};
          cnt_q  <= cnt_q + 1'b1;
        end
        FIX: begin
          quo_q  <= fix_quo;
          rem_q  <= fix_rem;
          err_q  <= fix_err;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_quotient  = quo_q;
  assign bus.o_remainder = rem_q;
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_mdr_divider.sv
// Testbench for mdr_divider: vector table plus multi-cycle corner sequences.
// Expected results queued at start, checked when o_done appears.
// Timing of busy/done checked on every operation.
module tb_mdr_divider;
  import pkg_system_mdr::*;

  localparam int DW = MDR_DW;

  typedef struct {
    data_in_t a;
    data_in_t b;
    data_in_t q;
    data_in_t r;
    logic     e;
  } vec_t;

  typedef struct {
    data_in_t q;
    data_in_t r;
    logic     e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mdr_divider_if #(.DW(DW)) bus();

  mdr_divider #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t     sb[$];
  vec_t     vt[$];
  int       n_vec = 0;
  int       n_bad = 0;
  data_in_t last_q, last_r;
  logic     last_e;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, DW'(bus.o_busy), '0);
    chk({tag, "_done"}, DW'(bus.o_done), '0);
    chk({tag, "_quo"},  bus.o_quotient,  '0);
    chk({tag, "_rem"},  bus.o_remainder, '0);
    chk({tag, "_err"},  DW'(bus.o_err),  '0);
  endtask

  // Issue one operation. inj_at>0 pulses a spurious start sampled at edge k+inj_at;
  // abort_at>0 pulls reset low right after edge k+abort_at.
  task automatic do_op(input data_in_t a, input data_in_t b, input data_in_t eq, input data_in_t er,
                       input logic ee, input int inj_at, input int abort_at);
    exp_t x;
    int   j;
    int   ndone;
    bit   seen;
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_dividend = a;
    bus.i_divisor  = b;
    x.q = eq; x.r = er; x.e = ee;
    sb.push_back(x);
    @(posedge clk); #1;
    bus.i_start    = 1'b0;
    bus.i_dividend = DW'($urandom);
    bus.i_divisor  = DW'($urandom);
    chk("busy_at_start", DW'(bus.o_busy), DW'(1));
    chk("done_at_start", DW'(bus.o_done), '0);
    seen = 0;
    j = 0;
    while (!seen && j < DW + 6) begin
      j++;
      if (j == inj_at) begin
        bus.i_start    = 1'b1;
        bus.i_dividend = 16'd1000;
        bus.i_divisor  = 16'd2;
      end
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      if (j == abort_at) begin
        rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        void'(sb.pop_back());
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        repeat (25) begin
          @(posedge clk); #1;
          if (bus.o_done) ndone++;
        end
        chk("no_done_after_abort", DW'(ndone), '0);
        return;
      end
      if (j == DW) chk("busy_last_cycle", DW'(bus.o_busy), DW'(1));
      if (bus.o_done) seen = 1;
    end
    if (!seen) begin
      chk("done_timeout", DW'(bus.o_done), DW'(1));
      void'(sb.pop_front());
      return;
    end
    chk("latency", DW'(j), DW'(DW + 1));
    chk("busy_at_done", DW'(bus.o_busy), '0);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", DW'(sb.size()), DW'(1));
    end else begin
      x = sb.pop_front();
      chk("quotient",  bus.o_quotient,  x.q);
      chk("remainder", bus.o_remainder, x.r);
      chk("err",       DW'(bus.o_err),  DW'(x.e));
      last_q = x.q; last_r = x.r; last_e = x.e;
    end
  endtask

  initial begin
    bus.i_start    = 1'b0;
    bus.i_dividend = '0;
    bus.i_divisor  = '0;

    vt.push_back('{16'd100,   16'd7,     16'd14,    16'd2,     1'b0});
    vt.push_back('{16'd1234,  16'd0,     16'hFFFF,  16'd1234,  1'b1});
    vt.push_back('{16'd10,    16'd3,     16'd3,     16'd1,     1'b0});
    vt.push_back('{16'd0,     16'd5,     16'd0,     16'd0,     1'b0});
    vt.push_back('{16'd7,     16'd9,     16'd0,     16'd7,     1'b0});
    vt.push_back('{16'd100,   16'd1,     16'd100,   16'd0,     1'b0});
`ifdef MDR_SIGNED_EN
    vt.push_back('{16'hFF9C,  16'd7,     16'hFFF2,  16'hFFFE,  1'b0});
    vt.push_back('{16'd100,   16'hFFF9,  16'hFFF2,  16'd2,     1'b0});
    vt.push_back('{16'hFF9C,  16'hFFF9,  16'd14,    16'hFFFE,  1'b0});
    vt.push_back('{16'h8000,  16'hFFFF,  16'h8000,  16'd0,     1'b1});
    vt.push_back('{16'hFFFB,  16'd0,     16'hFFFF,  16'hFFFB,  1'b1});
    vt.push_back('{16'h8000,  16'd1,     16'h8000,  16'd0,     1'b0});
`else
    vt.push_back('{16'hFFFF,  16'hFFFF,  16'd1,     16'd0,     1'b0});
    vt.push_back('{16'd40000, 16'd123,   16'd325,   16'd25,    1'b0});
    vt.push_back('{16'h8000,  16'hFFFF,  16'd0,     16'h8000,  1'b0});
    vt.push_back('{16'hFFFF,  16'd2,     16'h7FFF,  16'd1,     1'b0});
`endif

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("post_reset");

    for (int i = 0; i < vt.size(); i++)
      do_op(vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].e, -1, -1);

    // Spurious start mid-operation, then back-to-back at the earliest slot.
    do_op(16'd500, 16'd9, 16'd55, 16'd5, 1'b0, 5, -1);
    do_op(16'd10,  16'd3, 16'd3,  16'd1, 1'b0, -1, -1);

    // Reset mid-operation, then the same operation runs to completion.
    do_op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, -1, 8);
    do_op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, -1, -1);

    // Results hold with random operands and no start.
    repeat (40) begin
      @(negedge clk);
      bus.i_start    = 1'b0;
      bus.i_dividend = DW'($urandom);
      bus.i_divisor  = DW'($urandom);
      @(posedge clk); #1;
      chk("hold_quo",  bus.o_quotient,  last_q);
      chk("hold_rem",  bus.o_remainder, last_r);
      chk("hold_err",  DW'(bus.o_err),  DW'(last_e));
      chk("hold_done", DW'(bus.o_done), '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
